// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : register map, status bits and FSM states for the UART line |
// | reader.                                                              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

   localparam logic [1:0] ADDR_TX   = 2'd0;
   localparam logic [1:0] ADDR_RX   = 2'd1;
   localparam logic [1:0] ADDR_STAT = 2'd2;

   localparam int STAT_RX_NE   = 0;
   localparam int STAT_TX_FULL = 1;

   localparam logic [7:0] CR = 8'h0D;

   // The UART slave uses an inverted write-enable: 1 reads, 0 writes.
   localparam logic WE_READ  = 1'b1;
   localparam logic WE_WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_STAT = 3'd1,
      RD_RX   = 3'd2,
      EC_STAT = 3'd3,
      EC_WR   = 3'd4,
      STORE   = 3'd5,
      DRAIN   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_buf : DEPTH x 8 register array, synchronous write, asynchronous  |
// | read.                                                                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module line_buf
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_line_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_line_reader : Wishbone master that polls a UART, echoes and      |
// | assembles received bytes into lines, then streams each line out.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_line_reader
   import uart_pkg::*;
#(
   parameter int LINE_LEN    = 16,
   parameter int ECHO        = 1,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   input  logic [7:0] wb_data_in,
   output logic       wb_we,
   output logic       wb_stb,
   input  logic       wb_ack,
   output logic [7:0] line_data,
   output logic       line_valid,
   input  logic       line_ready,
   output logic       line_last,
   output logic       bus_err
);

   localparam int PTR_W = $clog2(LINE_LEN);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count, cnt_nxt;
   logic [PTR_W-1:0]   rd_ptr, rd_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
   logic [7:0]         rx_byte, rx_nxt;
   logic               stb_nxt, we_nxt, valid_nxt, last_nxt, err_nxt;
   logic [1:0]         addr_nxt;
   logic [7:0]         dout_nxt, data_nxt;
   logic               buf_we;
   logic [PTR_W-1:0]   buf_raddr;
   logic [7:0]         buf_rdata;
   logic               timed_out;

   line_buf #(
      .DEPTH (LINE_LEN),
      .AW    (PTR_W)
   ) u_line_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (count[PTR_W-1:0]),
      .wdata (rx_byte),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         rd_ptr      <= '0;
         tmo_cnt     <= '0;
         rx_byte     <= 8'h00;
         wb_stb      <= 1'b0;
         wb_we       <= WE_READ;
         wb_addr     <= ADDR_STAT;
         wb_data_out <= 8'h00;
         line_data   <= 8'h00;
         line_valid  <= 1'b0;
         line_last   <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= cnt_nxt;
         rd_ptr      <= rd_nxt;
         tmo_cnt     <= tmo_nxt;
         rx_byte     <= rx_nxt;
         wb_stb      <= stb_nxt;
         wb_we       <= we_nxt;
         wb_addr     <= addr_nxt;
         wb_data_out <= dout_nxt;
         line_data   <= data_nxt;
         line_valid  <= valid_nxt;
         line_last   <= last_nxt;
         bus_err     <= err_nxt;
      end
   end

   // While a byte is on the stream the next one is looked up one slot ahead.
   assign buf_raddr = line_valid ? rd_ptr + PTR_W'(1) : rd_ptr;
   assign timed_out = wb_stb && !wb_ack && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = count;
      rd_nxt    = rd_ptr;
      tmo_nxt   = '0;
      rx_nxt    = rx_byte;
      stb_nxt   = wb_stb;
      we_nxt    = wb_we;
      addr_nxt  = wb_addr;
      dout_nxt  = wb_data_out;
      data_nxt  = line_data;
      valid_nxt = line_valid;
      last_nxt  = line_last;
      err_nxt   = bus_err;
      buf_we    = 1'b0;

      if (wb_stb && !wb_ack) begin
         tmo_nxt = tmo_cnt + TMO_W'(1);
      end

      if (timed_out) begin
         stb_nxt   = 1'b0;
         err_nxt   = 1'b1;
         tmo_nxt   = '0;
         state_nxt = IDLE;
      end else begin
         // Bus states raise the strobe whenever it is low, so every cycle
         // is preceded by the idle cycle left by the previous ack.
         case (state)
            IDLE: begin
               stb_nxt   = 1'b1;
               addr_nxt  = ADDR_STAT;
               we_nxt    = WE_READ;
               state_nxt = RD_STAT;
            end
            RD_STAT: begin
               if (!wb_stb) begin
                  stb_nxt  = 1'b1;
                  addr_nxt = ADDR_STAT;
                  we_nxt   = WE_READ;
               end else if (wb_ack) begin
                  stb_nxt   = 1'b0;
                  state_nxt = wb_data_in[STAT_RX_NE] ? RD_RX : IDLE;
               end
            end
            RD_RX: begin
               if (!wb_stb) begin
                  stb_nxt  = 1'b1;
                  addr_nxt = ADDR_RX;
                  we_nxt   = WE_READ;
               end else if (wb_ack) begin
                  stb_nxt   = 1'b0;
                  rx_nxt    = wb_data_in;
                  state_nxt = (ECHO != 0) ? EC_STAT : STORE;
               end
            end
            EC_STAT: begin
               if (!wb_stb) begin
                  stb_nxt  = 1'b1;
                  addr_nxt = ADDR_STAT;
                  we_nxt   = WE_READ;
               end else if (wb_ack) begin
                  stb_nxt = 1'b0;
                  if (!wb_data_in[STAT_TX_FULL]) begin
                     state_nxt = EC_WR;
                  end
               end
            end
            EC_WR: begin
               if (!wb_stb) begin
                  stb_nxt  = 1'b1;
                  addr_nxt = ADDR_TX;
                  we_nxt   = WE_WRITE;
                  dout_nxt = rx_byte;
               end else if (wb_ack) begin
                  stb_nxt   = 1'b0;
                  state_nxt = STORE;
               end
            end
            STORE: begin
               if (rx_byte == CR) begin
                  state_nxt = (count != '0) ? DRAIN : IDLE;
               end else begin
                  buf_we    = 1'b1;
                  cnt_nxt   = count + CNT_W'(1);
                  state_nxt = (cnt_nxt == CNT_W'(LINE_LEN)) ? DRAIN : IDLE;
               end
            end
            DRAIN: begin
               if (!line_valid) begin
                  valid_nxt = 1'b1;
                  data_nxt  = buf_rdata;
                  last_nxt  = (({1'b0, rd_ptr} + CNT_W'(1)) == count);
               end else if (line_ready) begin
                  if (line_last) begin
                     valid_nxt = 1'b0;
                     last_nxt  = 1'b0;
                     cnt_nxt   = '0;
                     rd_nxt    = '0;
                     state_nxt = IDLE;
                  end else begin
                     rd_nxt   = rd_ptr + PTR_W'(1);
                     data_nxt = buf_rdata;
                     last_nxt = (({1'b0, rd_ptr} + CNT_W'(2)) == count);
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_line_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_line_reader : behavioural UART slave plus line-level model.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_line_reader;

   localparam int LINE_LEN    = 16;
   localparam int ECHO        = 1;
   localparam int ACK_TIMEOUT = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] wb_addr;
   logic [7:0] wb_data_out;
   logic [7:0] wb_data_in = 8'h00;
   logic       wb_we;
   logic       wb_stb;
   logic       wb_ack = 1'b0;
   logic [7:0] line_data;
   logic       line_valid;
   logic       line_ready = 1'b0;
   logic       line_last;
   logic       bus_err;

   uart_line_reader #(
      .LINE_LEN    (LINE_LEN),
      .ECHO        (ECHO),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_addr     (wb_addr),
      .wb_data_out (wb_data_out),
      .wb_data_in  (wb_data_in),
      .wb_we       (wb_we),
      .wb_stb      (wb_stb),
      .wb_ack      (wb_ack),
      .line_data   (line_data),
      .line_valid  (line_valid),
      .line_ready  (line_ready),
      .line_last   (line_last),
      .bus_err     (bus_err)
   );

   initial forever #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART slave state and observations
   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   logic [8:0] got_q[$];
   int  lat = 0, tx_full_cnt = 0, full_polls = 0;
   bit  no_ack = 0, rx_allowed = 0, echo_pending = 0, last_stat_full = 0;
   int  bus_viol = 0, hold_viol = 0;
   int  stb_run = 0, last_stb_len = 0, stb_count = 0;
   int  vrun = 0, last_vrun = 0;
   bit  hold_pending = 0;
   logic [8:0] hold_val;
   logic [1:0] cap_addr;
   logic       cap_we;
   logic [7:0] cap_dout;

   // Reference model: lines split on CR or at LINE_LEN bytes, every byte echoed
   logic [7:0] mdl_line[$];
   logic [8:0] exp_q[$];
   logic [7:0] exp_tx[$];

   task automatic mdl_flush();
      for (int i = 0; i < mdl_line.size(); i++)
         exp_q.push_back({(i == mdl_line.size() - 1), mdl_line[i]});
      mdl_line.delete();
   endtask

   task automatic send(input logic [7:0] b);
      rx_q.push_back(b);
      exp_tx.push_back(b);
      if (b == 8'h0D) begin
         if (mdl_line.size() > 0) mdl_flush();
      end else begin
         mdl_line.push_back(b);
         if (mdl_line.size() == LINE_LEN) mdl_flush();
      end
   endtask

   task automatic slave_access();
      logic rx_ne, full;
      if (cap_we) begin
         if (cap_addr == 2'd2) begin
            rx_ne = (rx_q.size() > 0);
            full  = echo_pending && (tx_full_cnt > 0);
            if (full) begin
               tx_full_cnt--;
               full_polls++;
            end
            wb_data_in     = {6'b0, full, rx_ne};
            rx_allowed     = rx_ne;
            last_stat_full = full;
         end else if (cap_addr == 2'd1) begin
            if (!rx_allowed) bus_viol++;
            wb_data_in   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            rx_allowed   = 0;
            echo_pending = 1;
         end else begin
            wb_data_in = 8'h00;
            bus_viol++;
         end
      end else begin
         if (cap_addr != 2'd0 || last_stat_full || !echo_pending) bus_viol++;
         tx_log.push_back(cap_dout);
         echo_pending = 0;
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         wb_ack = 1'b0;
         lat = 0; stb_run = 0; vrun = 0; hold_pending = 0;
      end else begin
         if (wb_ack) begin
            if (wb_stb) bus_viol++;
            wb_ack = 1'b0;
            lat = 0;
         end else if (wb_stb) begin
            if (lat == 0) begin
               cap_addr = wb_addr; cap_we = wb_we; cap_dout = wb_data_out;
            end else if (wb_addr !== cap_addr || wb_we !== cap_we || wb_data_out !== cap_dout) begin
               bus_viol++;
            end
            lat++;
            if (!no_ack && lat == 2) begin
               slave_access();
               wb_ack = 1'b1;
            end
         end else begin
            lat = 0;
         end

         if (wb_stb) stb_run++;
         else if (stb_run > 0) begin
            last_stb_len = stb_run; stb_run = 0; stb_count++;
         end

         if (line_valid) begin
            if (hold_pending && {line_last, line_data} !== hold_val) hold_viol++;
            if (line_ready) begin
               got_q.push_back({line_last, line_data});
               hold_pending = 0;
            end else begin
               hold_pending = 1;
               hold_val = {line_last, line_data};
            end
            vrun++;
         end else begin
            if (hold_pending) hold_viol++;
            hold_pending = 0;
            if (vrun > 0) begin
               last_vrun = vrun; vrun = 0;
            end
         end
      end
   end

   bit ready_rand = 0;
   bit ready_val  = 1;
   initial forever begin
      @(posedge clk);
      #1;
      line_ready = ready_rand ? ($urandom_range(0, 99) < 65) : ready_val;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic cmp_stream(input string tag);
      int n;
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic cmp_tx(input string tag);
      int n;
      check({tag, "_txlen"}, 32'(tx_log.size()), 32'(exp_tx.size()));
      n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
      tx_log.delete();
      exp_tx.delete();
   endtask

   task automatic settle(input string tag, input int budget);
      int n = 0;
      while ((rx_q.size() != 0 || got_q.size() < exp_q.size() || tx_log.size() < exp_tx.size())
             && n < budget) begin
         tick();
         n++;
      end
      repeat (40) tick();
      cmp_stream(tag);
      cmp_tx(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stb"},   32'(wb_stb),      32'd0);
      check({tag, "_we"},    32'(wb_we),       32'd1);
      check({tag, "_addr"},  32'(wb_addr),     32'd2);
      check({tag, "_dout"},  32'(wb_data_out), 32'h00);
      check({tag, "_valid"}, 32'(line_valid),  32'd0);
      check({tag, "_last"},  32'(line_last),   32'd0);
      check({tag, "_err"},   32'(bus_err),     32'd0);
   endtask

   initial begin
      int n, cnt0;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b0;

      // Test 1: "AB" CR with echo
      send(8'h41); send(8'h42); send(8'h0D);
      settle("t1", 3000);
      check("t1_run", 32'(last_vrun), 32'd2);

      // Test 2: full buffer without CR
      for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
      settle("t2", 6000);
      check("t2_run", 32'(last_vrun), 32'd16);

      // Test 3: lone CR, then "Z" CR
      send(8'h0D);
      settle("t3a", 2000);
      send(8'h5A); send(8'h0D);
      settle("t3b", 2000);

      // Test 4: TX full for 20 echo polls
      full_polls  = 0;
      tx_full_cnt = 20;
      ready_rand  = 1;
      send(8'h51); send(8'h0D);
      settle("t4", 4000);
      check("t4_polls", 32'(full_polls), 32'd20);

      // Random lines, random back-pressure
      for (int l = 0; l < 6; l++) begin
         int len;
         len = $urandom_range(0, 20);
         for (int k = 0; k < len; k++) send(8'($urandom_range(32, 126)));
         if ($urandom_range(0, 3) != 0) send(8'h0D);
      end
      send(8'h0D);
      settle("t7", 20000);

      // Test 5: ack timeout keeps the partial line
      send(8'h58); send(8'h59);
      settle("t5a", 2000);
      no_ack = 1;
      n = 0;
      while (!bus_err && n < 2000) begin tick(); n++; end
      check("t5_err", 32'(bus_err), 32'd1);
      check("t5_stb_len", 32'(last_stb_len), 32'(ACK_TIMEOUT));
      check("t5_stb_low", 32'(wb_stb), 32'd0);
      no_ack = 0;
      cnt0 = stb_count;
      repeat (60) tick();
      check("t5_err_sticky", 32'(bus_err), 32'd1);
      check("t5_resumed", 32'(stb_count > cnt0 + 2), 32'd1);
      send(8'h5A); send(8'h0D);
      settle("t5b", 3000);
      check("t5_err_end", 32'(bus_err), 32'd1);

      // Test 6: asynchronous reset while draining under back-pressure
      ready_rand = 0;
      ready_val  = 0;
      send(8'h52); send(8'h53); send(8'h54); send(8'h0D);
      n = 0;
      while (!line_valid && n < 3000) begin tick(); n++; end
      check("t6_valid", 32'(line_valid), 32'd1);
      cmp_tx("t6");
      #2 reset = 1'b1;
      #1 check_reset_outputs("t6_rst");
      repeat (2) tick();
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      mdl_line.delete();
      ready_val = 1;
      repeat (100) tick();
      check("t6_quiet", 32'(got_q.size()), 32'd0);
      send(8'h4F); send(8'h4B); send(8'h0D);
      settle("t6b", 3000);

      check("bus_protocol", 32'(bus_viol), 32'd0);
      check("stream_hold", 32'(hold_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
